// File: rtl/input_debounce_edge_pkg.sv
// Shared encodings for debounce-style FSMs.
// The state values are fixed so that later keypad scanner and edge-counter
// stages can decode the same encoding.
package input_debounce_edge_pkg;

  // Debounce FSM states: two settled levels, each with a matching check state
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } db_state_t;

  // True while a candidate transition is being qualified
  function automatic logic is_check(input db_state_t st);
    return (st == CHECK_HIGH) || (st == CHECK_LOW);
  endfunction

endpackage

// File: rtl/input_debounce_edge_sync_ff_chain.sv
// Multi-flop synchroniser used wherever an asynchronous level enters
// the clk domain. The chain has no enable and always shifts.
module sync_ff_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clear_n,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the raw level toward the output; stage 0 is the metastable catcher
  always_ff @(posedge clk) begin
    if (!clear_n) chain <= '0;
    else          chain <= {chain[SYNC_STAGES-2:0], async_in};
  end

  assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/input_debounce_edge.sv
// Debounced level source for the D flip-flop stage.
// A raw pin is synchronised and must hold a new level for STABLE_COUNT
// checked cycles before d follows it. rise/fall pulse for one cycle in the
// cycle d first shows its new value. en=0 freezes the qualifier but not the
// synchroniser.
module input_debounce_edge
  import input_debounce_edge_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_COUNT = 10,
  parameter int CNT_WIDTH    = 4
) (
  input  logic clk,
  input  logic clear_n,
  input  logic din,
  input  logic en,
  output logic d,
  output logic rise,
  output logic fall,
  output logic busy
);

  // The last count value of a check; reaching it with s still matching fires
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

  logic                 s;
  db_state_t            state;
  logic [CNT_WIDTH-1:0] cnt;

  sync_ff_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .clear_n  (clear_n),
    .async_in (din),
    .sync_out (s)
  );

  // Debounce FSM with registered level, edge pulses and busy flag.
  // The counter is cleared on every check entry and exit, so it never
  // exceeds CNT_LAST and cannot wrap.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state <= STABLE_LOW;
      cnt   <= '0;
      d     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      // Pulses last one cycle; they are also forced low while frozen
      rise <= 1'b0;
      fall <= 1'b0;
      if (en) begin
        case (state)
          STABLE_LOW: begin
            if (s) begin
              state <= CHECK_HIGH;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          CHECK_HIGH: begin
            if (!s) begin
              // Glitch rejected: go back without touching d
              state <= STABLE_LOW;
              cnt   <= '0;
              busy  <= 1'b0;
            end else if (cnt == CNT_LAST) begin
              state <= STABLE_HIGH;
              cnt   <= '0;
              d     <= 1'b1;
              rise  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STABLE_HIGH: begin
            if (!s) begin
              state <= CHECK_LOW;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          CHECK_LOW: begin
            if (s) begin
              state <= STABLE_HIGH;
              cnt   <= '0;
              busy  <= 1'b0;
            end else if (cnt == CNT_LAST) begin
              state <= STABLE_LOW;
              cnt   <= '0;
              d     <= 1'b0;
              fall  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= STABLE_LOW;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_input_debounce_edge.sv
// Directed bench for input_debounce_edge at default parameters.
// Edge k is the k-th rising clk edge after the stimulus change; outputs
// are sampled 1 ns after each edge.
module tb_input_debounce_edge;

  logic clk = 1'b0;
  logic clear_n;
  logic din;
  logic en;
  logic d, rise, fall, busy;

  int n_chk  = 0;
  int n_pass = 0;

  input_debounce_edge dut (
    .clk     (clk),
    .clear_n (clear_n),
    .din     (din),
    .en      (en),
    .d       (d),
    .rise    (rise),
    .fall    (fall),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for 3 edges with the given din level, then release
  task automatic do_reset(input logic lvl);
    clear_n = 1'b0;
    din     = lvl;
    repeat (3) step();
    clear_n = 1'b1;
  endtask

  initial begin
    clear_n = 1'b0;
    din     = 1'b1;
    en      = 1'b1;
    #1;

    // Reset with din=1: outputs stay at reset values
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("rst_d e%0d", k), d, 1'b0);
      chk($sformatf("rst_rise e%0d", k), rise, 1'b0);
      chk($sformatf("rst_busy e%0d", k), busy, 1'b0);
    end
    // After release the held-high pin must qualify at edge 13
    clear_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk($sformatf("post_rst_rise e%0d", k), rise, k == 13);
      chk($sformatf("post_rst_d e%0d", k), d, k >= 13);
    end

    // Clean rise from a settled low
    do_reset(1'b0);
    repeat (4) step();
    din = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      chk($sformatf("rise_busy e%0d", k), busy, (k >= 3) && (k <= 12));
      chk($sformatf("rise_d e%0d", k), d, k >= 13);
      chk($sformatf("rise_rise e%0d", k), rise, k == 13);
      chk($sformatf("rise_fall e%0d", k), fall, 1'b0);
    end

    // Glitch: din high for 5 edges only
    do_reset(1'b0);
    repeat (4) step();
    din = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 5) din = 1'b0;
      chk($sformatf("glitch_busy e%0d", k), busy, (k >= 3) && (k <= 7));
      chk($sformatf("glitch_d e%0d", k), d, 1'b0);
      chk($sformatf("glitch_rise e%0d", k), rise, 1'b0);
    end

    // Clean fall from d=1
    do_reset(1'b1);
    repeat (16) step();
    chk("fall_pre_d", d, 1'b1);
    din = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk($sformatf("fall_fall e%0d", k), fall, k == 13);
      chk($sformatf("fall_d e%0d", k), d, k < 13);
      chk($sformatf("fall_rise e%0d", k), rise, 1'b0);
      chk($sformatf("fall_busy e%0d", k), busy, (k >= 3) && (k <= 12));
    end

    // Enable frozen for edges 6..9 of a rise check
    do_reset(1'b0);
    repeat (4) step();
    din = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 5) en = 1'b0;
      if (k == 9) en = 1'b1;
      chk($sformatf("en_rise e%0d", k), rise, k == 17);
      chk($sformatf("en_d e%0d", k), d, k >= 17);
      chk($sformatf("en_busy e%0d", k), busy, (k >= 3) && (k <= 16));
    end

    // Reset asserted at edge 5 of a fall check
    do_reset(1'b1);
    repeat (16) step();
    chk("mid_pre_d", d, 1'b1);
    din = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("mid_d e%0d", k), d, 1'b1);
      chk($sformatf("mid_busy e%0d", k), busy, k >= 3);
    end
    clear_n = 1'b0;
    step();
    chk("mid_rst_d", d, 1'b0);
    chk("mid_rst_fall", fall, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    clear_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk($sformatf("mid_after_fall e%0d", k), fall, 1'b0);
      chk($sformatf("mid_after_d e%0d", k), d, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
